// File: rtl/conv_job_sched_if.sv
// Job descriptor handshake between the host and the conv job scheduler.
// master: host drives job_valid and the descriptor; slave: scheduler drives job_ready.
interface conv_job_sched_if;
    logic        job_valid;
    logic        job_ready;
    logic [11:0] job_in_base;
    logic [11:0] job_out_base;
    logic [11:0] job_w_addr;

    modport master (
        output job_valid,
        output job_in_base,
        output job_out_base,
        output job_w_addr,
        input  job_ready
    );

    modport slave (
        input  job_valid,
        input  job_in_base,
        input  job_out_base,
        input  job_w_addr,
        output job_ready
    );
endinterface

// File: rtl/conv_job_sched.sv
// Convolution job scheduler: queues job descriptors from the host, launches them
// one at a time on the convolution engine and reports completion via irq.
// Ports: clk, reset_b (async, active-low); job (conv_job_sched_if.slave) host queue
// input; eng_run / eng_busy / eng_in_base / eng_out_base / eng_w_addr engine side;
// irq / irq_clr sticky interrupt; jobs_done completion count; err_timeout watchdog
// flag; sched_idle idle status.
// Optional feature: define CONV_SCHED_TIMEOUT_EN to add the per-job watchdog.
module conv_job_sched #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset_b,
    conv_job_sched_if.slave        job,
    output logic                   eng_run,
    input  logic                   eng_busy,
    output logic [11:0]            eng_in_base,
    output logic [11:0]            eng_out_base,
    output logic [11:0]            eng_w_addr,
    output logic                   irq,
    input  logic                   irq_clr,
    output logic [7:0]             jobs_done,
    output logic                   err_timeout,
    output logic                   sched_idle
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("conv_job_sched: unsupported parameter value");
    end

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [35:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [35:0]   head;
    logic          wdog_hit;
    logic          active;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = job.job_valid && !full;
    assign pop   = (state == S_LAUNCH) && !empty;
    assign head  = fifo_mem[rd_ptr];

    assign job.job_ready = !full;
    assign sched_idle    = (state == S_IDLE) && empty;
    assign eng_run       = (state == S_LAUNCH);
    assign active        = (state == S_WAIT) || (state == S_RUN);

    // Queue storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {job.job_in_base, job.job_out_base, job.job_w_addr};
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (wdog_hit) begin
                    state_nx = S_IDLE;
                end else if (eng_busy) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (wdog_hit) begin
                    state_nx = S_IDLE;
                end else if (!eng_busy) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = empty ? S_IDLE : S_LAUNCH;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Descriptor is captured on entry to LAUNCH so it is already valid
    // in the cycle eng_run is high and holds until the next launch.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            eng_in_base  <= '0;
            eng_out_base <= '0;
            eng_w_addr   <= '0;
        end else if (state_nx == S_LAUNCH) begin
            {eng_in_base, eng_out_base, eng_w_addr} <= head;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            jobs_done <= '0;
        end else if (state == S_DONE) begin
            jobs_done <= jobs_done + 8'd1;
        end
    end

    // A set event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            irq <= 1'b0;
        end else if ((state == S_DONE) || wdog_hit) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] wdog;
    logic          err_q;

    assign wdog_hit    = active && (wdog == TW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wdog <= '0;
        end else if (state == S_LAUNCH) begin
            wdog <= '0;
        end else if (active && !wdog_hit) begin
            wdog <= wdog + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            err_q <= 1'b0;
        end else if (wdog_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign wdog_hit    = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_conv_job_sched.sv
// Directed, table-driven bench for conv_job_sched with a small engine responder.
// Build with or without CONV_SCHED_TIMEOUT_EN to cover both watchdog variants.
module tb_conv_job_sched;

    typedef struct {
        logic [11:0] in_b;
        logic [11:0] out_b;
        logic [11:0] w;
        int          blen;
        logic [7:0]  exp_done;
    } vec_t;

    typedef struct {
        int          c;
        logic [11:0] in_b;
    } run_t;

    logic        clk;
    logic        reset_b;
    logic        eng_run;
    logic        eng_busy;
    logic [11:0] eng_in_base;
    logic [11:0] eng_out_base;
    logic [11:0] eng_w_addr;
    logic        irq;
    logic        irq_clr;
    logic [7:0]  jobs_done;
    logic        err_timeout;
    logic        sched_idle;

    conv_job_sched_if jif ();

    conv_job_sched #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .job          (jif),
        .eng_run      (eng_run),
        .eng_busy     (eng_busy),
        .eng_in_base  (eng_in_base),
        .eng_out_base (eng_out_base),
        .eng_w_addr   (eng_w_addr),
        .irq          (irq),
        .irq_clr      (irq_clr),
        .jobs_done    (jobs_done),
        .err_timeout  (err_timeout),
        .sched_idle   (sched_idle)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   run_cnt = 0;
    int   gap_err = 0;
    int   last_run = -100;
    int   busy_len = 20;
    int   bcnt = 0;
    bit   eng_auto = 1'b1;
    bit   man_busy = 1'b0;
    run_t log_q[$];
    vec_t vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine responder: busy rises in the eng_run cycle and stays up for
    // busy_len negedge intervals; man_busy allows manual control.
    always @(negedge clk) begin
        if (eng_run) begin
            run_cnt++;
            log_q.push_back('{c: cyc, in_b: eng_in_base});
            if (cyc - last_run < 4) gap_err++;
            last_run = cyc;
            if (eng_auto) bcnt = busy_len;
        end else if (bcnt > 0) begin
            bcnt--;
        end
        eng_busy = (bcnt > 0) || man_busy;
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_eng_run"}, eng_run, 0);
        check({tag, "_eng_in"}, eng_in_base, 0);
        check({tag, "_eng_out"}, eng_out_base, 0);
        check({tag, "_eng_w"}, eng_w_addr, 0);
        check({tag, "_irq"}, irq, 0);
        check({tag, "_jobs_done"}, jobs_done, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_job_ready"}, jif.job_ready, 1);
        check({tag, "_sched_idle"}, sched_idle, 1);
    endtask

    task automatic push_job(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c);
        int t;
        t = 0;
        @(negedge clk);
        jif.job_valid    = 1'b1;
        jif.job_in_base  = a;
        jif.job_out_base = b;
        jif.job_w_addr   = c;
        while (!jif.job_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_chk++;
            $display("FAIL push_timeout: job %0h not accepted in %0d cycles", a, t);
        end
        @(posedge clk);
        #1;
        jif.job_valid = 1'b0;
    endtask

    task automatic wait_run(input string nm, input logic [11:0] inb,
                            input int lim);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (eng_run && eng_in_base == inb) begin
                ok = 1'b1;
                break;
            end
        end
        check(nm, ok, 1);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (sched_idle) break;
        end
        check(nm, sched_idle, 1);
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
    endtask

    initial begin
        int          r0;
        int          s;
        int          t;
        logic [7:0]  exp_jobs;
        logic [11:0] fill_order[6];

        vecs[0] = '{in_b: 12'h000, out_b: 12'h040, w: 12'h001, blen: 20, exp_done: 8'd1};
        vecs[1] = '{in_b: 12'hFFF, out_b: 12'hABC, w: 12'h123, blen: 2,  exp_done: 8'd2};
        vecs[2] = '{in_b: 12'h5A5, out_b: 12'hA5A, w: 12'h0F0, blen: 7,  exp_done: 8'd3};
        vecs[3] = '{in_b: 12'h800, out_b: 12'h001, w: 12'h7FF, blen: 3,  exp_done: 8'd4};
        fill_order = '{12'h100, 12'h201, 12'h202, 12'h203, 12'h204, 12'h205};

        reset_b          = 1'b0;
        irq_clr          = 1'b0;
        jif.job_valid    = 1'b0;
        jif.job_in_base  = '0;
        jif.job_out_base = '0;
        jif.job_w_addr   = '0;
        #1;
        check_reset("por");
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);

        // single jobs from the table
        for (int i = 0; i < 4; i++) begin
            busy_len = vecs[i].blen;
            r0 = run_cnt;
            push_job(vecs[i].in_b, vecs[i].out_b, vecs[i].w);
            wait_idle("v_idle", 500);
            check("v_runs", run_cnt - r0, 1);
            check("v_eng_in", eng_in_base, vecs[i].in_b);
            check("v_eng_out", eng_out_base, vecs[i].out_b);
            check("v_eng_w", eng_w_addr, vecs[i].w);
            check("v_jobs_done", jobs_done, vecs[i].exp_done);
            check("v_irq", irq, 1);
            pulse_clr();
            check("v_irq_clr", irq, 0);
        end
        exp_jobs = 8'd4;

        // fill the queue behind a running job
        s = log_q.size();
        busy_len = 40;
        push_job(12'h100, 12'h101, 12'h102);
        wait_run("fill_a_run", 12'h100, 20);
        busy_len = 10;
        for (int k = 1; k <= 4; k++) begin
            push_job(fill_order[k], fill_order[k] + 12'h010, fill_order[k] + 12'h020);
        end
        @(negedge clk);
        check("fill_full_ready", jif.job_ready, 0);
        check("fill_not_idle", sched_idle, 0);
        r0 = run_cnt;
        push_job(fill_order[5], 12'h215, 12'h225);
        check("fill_5th_after_pop", run_cnt - r0, 1);
        wait_idle("fill_idle", 1500);
        check("fill_count", log_q.size() - s, 6);
        for (int k = 0; k < 6; k++) begin
            check("fill_order", log_q[s + k].in_b, fill_order[k]);
        end
        exp_jobs += 8'd6;
        check("fill_jobs_done", jobs_done, exp_jobs);

        // push and pop in the same cycle with one job queued
        s = log_q.size();
        busy_len = 10;
        push_job(12'h310, 12'h311, 12'h312);
        wait_run("pp_x_run", 12'h310, 20);
        busy_len = 2;
        push_job(12'h320, 12'h321, 12'h322);
        wait_run("pp_y_run", 12'h320, 40);
        check("pp_ready", jif.job_ready, 1);
        jif.job_valid    = 1'b1;
        jif.job_in_base  = 12'h330;
        jif.job_out_base = 12'h331;
        jif.job_w_addr   = 12'h332;
        @(posedge clk);
        #1;
        jif.job_valid = 1'b0;
        wait_run("pp_z_run", 12'h330, 20);
        wait_idle("pp_idle", 200);
        check("pp_count", log_q.size() - s, 3);
        check("pp_gap", log_q[s + 2].c - log_q[s + 1].c, 4);
        exp_jobs += 8'd3;
        check("pp_jobs_done", jobs_done, exp_jobs);

        // irq_clr during DONE, then one cycle later
        pulse_clr();
        check("ic_pre", irq, 0);
        busy_len = 5;
        push_job(12'h400, 12'h401, 12'h402);
        wait_run("ic_run", 12'h400, 20);
        repeat (6) @(negedge clk);
        check("ic_done_irq", irq, 0);
        irq_clr = 1'b1;
        @(negedge clk);
        check("ic_set_wins", irq, 1);
        exp_jobs += 8'd1;
        check("ic_jobs_done", jobs_done, exp_jobs);
        @(negedge clk);
        check("ic_cleared", irq, 0);
        irq_clr = 1'b0;
        wait_idle("ic_idle", 50);

`ifdef CONV_SCHED_TIMEOUT_EN
        // engine never answers: watchdog expires, next job launches
        eng_auto = 1'b0;
        push_job(12'h600, 12'h601, 12'h602);
        push_job(12'h610, 12'h611, 12'h612);
        wait_run("wd_run", 12'h600, 20);
        t = 0;
        while (!err_timeout && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("wd_err", err_timeout, 1);
        n_chk++;
        if (t == 16 || t == 17) n_pass++;
        else $display("FAIL wd_cycles: got %0d expected 16..17", t);
        check("wd_irq", irq, 1);
        check("wd_jobs_done", jobs_done, exp_jobs);
        wait_run("wd_next_run", 12'h610, 10);
        man_busy = 1'b1;
        repeat (2) @(negedge clk);
        man_busy = 1'b0;
        wait_idle("wd_idle", 50);
        exp_jobs += 8'd1;
        check("wd_next_done", jobs_done, exp_jobs);
        check("wd_err_sticky", err_timeout, 1);
        eng_auto = 1'b1;
`else
        // no watchdog: job waits indefinitely for the engine
        eng_auto = 1'b0;
        push_job(12'h500, 12'h501, 12'h502);
        wait_run("nw_run", 12'h500, 20);
        repeat (60) @(negedge clk);
        check("nw_err", err_timeout, 0);
        check("nw_busy_wait", sched_idle, 0);
        check("nw_jobs_done", jobs_done, exp_jobs);
        man_busy = 1'b1;
        repeat (2) @(negedge clk);
        man_busy = 1'b0;
        wait_idle("nw_idle", 50);
        exp_jobs += 8'd1;
        check("nw_done", jobs_done, exp_jobs);
        eng_auto = 1'b1;
`endif

        // asynchronous reset while running with two jobs queued
        busy_len = 30;
        push_job(12'h700, 12'h701, 12'h702);
        wait_run("rst_run", 12'h700, 20);
        push_job(12'h710, 12'h711, 12'h712);
        push_job(12'h720, 12'h721, 12'h722);
        repeat (5) @(negedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        reset_b = 1'b1;
        r0 = run_cnt;
        repeat (50) @(negedge clk);
        check("rst_no_run", run_cnt - r0, 0);
        busy_len = 4;
        push_job(12'h730, 12'h731, 12'h732);
        wait_run("rst_new_run", 12'h730, 20);
        wait_idle("rst_idle", 100);
        check("rst_runs", run_cnt - r0, 1);
        check("rst_jobs_done", jobs_done, 1);
        check("rst_eng_out", eng_out_base, 12'h731);

        check("run_spacing", gap_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
